// File: rtl/riscv_if_parcel_queue.sv
// rtl/riscv_if_parcel_queue.sv - fetch parcel queue assembling RV32/RVC instructions
// Circular buffer of 16-bit parcels with per-parcel PC and fault tags.
module riscv_if_parcel_queue #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 8,
  parameter int HAS_RVC     = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     parcel_i,
  input  logic [XLEN-1:0] parcel_pc_i,
  input  logic [1:0]      parcel_valid_i,
  input  logic            parcel_error_i,
  input  logic            parcel_misaligned_i,
  output logic            parcel_ready_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  output logic            instr_rvc_o,
  output logic            instr_error_o,
  output logic            instr_misaligned_o,
  input  logic            instr_ack_i
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]     parcel_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem     [QUEUE_DEPTH];
  logic            err_mem    [QUEUE_DEPTH];
  logic            mis_mem    [QUEUE_DEPTH];

  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;

  logic [PW-1:0] rptr1, wptr1;
  logic [CW-1:0] free_slots;
  logic          push_en, pop_en;
  logic [CW-1:0] push_n, pop_n;
  logic          head_is32, head_err, have_two;
  logic [15:0]   first_parcel;
  logic [XLEN-1:0] first_pc, upper_pc;

  assign rptr1 = rptr + 1'b1;
  assign wptr1 = wptr + 1'b1;

  assign free_slots     = CW'(QUEUE_DEPTH) - count;
  assign parcel_ready_o = free_slots >= CW'(2);

  assign push_en = parcel_ready_o && (parcel_valid_i != 2'b00) && !flush_i;
  assign push_n  = (parcel_valid_i == 2'b11) ? CW'(2) : CW'(1);

  assign upper_pc     = parcel_pc_i + XLEN'(2);
  // The first written slot holds the lower parcel unless only the upper one is valid.
  assign first_parcel = parcel_valid_i[0] ? parcel_i[15:0] : parcel_i[31:16];
  assign first_pc     = parcel_valid_i[0] ? parcel_pc_i : upper_pc;

  assign head_is32 = (HAS_RVC == 0) || (parcel_mem[rptr][1:0] == 2'b11);
  assign head_err  = err_mem[rptr];
  assign have_two  = count >= CW'(2);

  always_comb begin
    instr_valid_o      = 1'b0;
    instr_o            = {16'h0000, parcel_mem[rptr]};
    instr_pc_o         = pc_mem[rptr];
    instr_rvc_o        = !head_is32;
    instr_error_o      = head_err;
    instr_misaligned_o = mis_mem[rptr];
    pop_n              = CW'(2);
    if (count != '0) begin
      instr_valid_o = !head_is32 || head_err || have_two;
    end
    if (head_is32) begin
      instr_o            = {parcel_mem[rptr1], parcel_mem[rptr]};
      instr_error_o      = head_err || (have_two && err_mem[rptr1]);
      instr_misaligned_o = mis_mem[rptr] || (have_two && mis_mem[rptr1]);
    end
    // A faulted lone half-instruction is delivered alone so the trap can be taken.
    if (!head_is32 || (head_err && count == CW'(1))) begin
      pop_n = CW'(1);
    end
  end

  assign pop_en = instr_valid_o && instr_ack_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      parcel_mem[wptr] <= first_parcel;
      pc_mem[wptr]     <= first_pc;
      err_mem[wptr]    <= parcel_error_i;
      mis_mem[wptr]    <= parcel_misaligned_i;
      if (parcel_valid_i == 2'b11) begin
        parcel_mem[wptr1] <= parcel_i[31:16];
        pc_mem[wptr1]     <= upper_pc;
        err_mem[wptr1]    <= parcel_error_i;
        mis_mem[wptr1]    <= parcel_misaligned_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + PW'(push_n);
      if (pop_en)  rptr <= rptr + PW'(pop_n);
      count <= count + (push_en ? push_n : CW'(0)) - (pop_en ? pop_n : CW'(0));
    end
  end

endmodule
